// File: rtl/bus_decoder_ws.sv
// Registered CPU-bus address decoder: one-hot region select held for a
// per-region wait count, then a one-cycle ready (or error for unmapped regions).
module bus_decoder_ws #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned SEL_W    = 3,
    localparam int unsigned NREG    = 2 ** SEL_W,
    parameter logic [4*NREG-1:0] WAIT_CFG = 32'h3000_0000,
    parameter logic [NREG-1:0]   MAP_MASK = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] add,
    input  logic              we,
    output logic [NREG-1:0]   cs,
    output logic              cs_we,
    output logic [SEL_W-1:0]  region,
    output logic              busy,
    output logic              rdy,
    output logic              err
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ERR
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [NREG-1:0]    cs_d;
    logic               cs_we_d;
    logic [SEL_W-1:0]   region_d;
    logic               busy_d;
    logic               rdy_d;
    logic               err_d;

    logic [SEL_W-1:0]   sel;
    logic [CNT_W-1:0]   wait_sel;

    // Only the region bits of the address matter to the decoder.
    logic unused_addr;
    assign unused_addr = ^add[ADDR_W-SEL_W-1:0];

    assign sel      = add[ADDR_W-1 -: SEL_W];
    assign wait_sel = WAIT_CFG[CNT_W*32'(sel) +: CNT_W];

    // Next-state and next-output logic; rdy/err are pulses so they default low.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        cs_d     = cs;
        cs_we_d  = cs_we;
        region_d = region;
        busy_d   = busy;
        rdy_d    = 1'b0;
        err_d    = 1'b0;
        case (state)
            S_IDLE: begin
                cs_d    = '0;
                cs_we_d = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                if (en) begin
                    region_d = sel;
                    busy_d   = 1'b1;
                    cnt_d    = wait_sel;
                    if (MAP_MASK[sel]) begin
                        state_d = S_ACCESS;
                        cs_d    = NREG'(1) << sel;
                        cs_we_d = we;
                        rdy_d   = (wait_sel == '0);
                    end else begin
                        state_d = S_ERR;
                        rdy_d   = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                    rdy_d = (cnt == CNT_W'(1));
                end else begin
                    state_d = S_IDLE;
                    cs_d    = '0;
                    cs_we_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                cs_d    = '0;
                cs_we_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            cs     <= '0;
            cs_we  <= 1'b0;
            region <= '0;
            busy   <= 1'b0;
            rdy    <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            cs     <= cs_d;
            cs_we  <= cs_we_d;
            region <= region_d;
            busy   <= busy_d;
            rdy    <= rdy_d;
            err    <= err_d;
        end
    end

endmodule

// File: doc/bus_decoder_ws.md
Name: bus_decoder_ws

Overview:
- Parametrised, registered address decoder with a wait-state sequencer for the RISC CPU bus.
- Splits the address space into 2**SEL_W equal regions, selected by the top SEL_W address bits.
- Drives a one-hot chip select, holds it for a per-region number of wait cycles, then pulses ready.
- Unmapped regions return an error pulse instead of a select. Sits between the CPU bus master and the memory/I-O slaves.

Parameters:
- ADDR_W, 16, address width in bits.
- SEL_W, 3, number of top address bits used for region select; NREG = 2**SEL_W.
- WAIT_CFG, 32'h3000_0000, flat NREG*4-bit vector; nibble i = wait cycles for region i (0..15).
- MAP_MASK, 8'hFF, NREG-bit vector; bit i = 1 means region i is mapped.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  bus request, sampled only in IDLE.
- add  in  ADDR_W  request address, sampled with en.
- we  in  1  write strobe, sampled with en.
- cs  out  NREG  registered one-hot region select.
- cs_we  out  1  registered copy of captured we, valid while cs is nonzero.
- region  out  SEL_W  captured region index = add[ADDR_W-1 -: SEL_W].
- busy  out  1  high from capture through the rdy cycle inclusive.
- rdy  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with rdy, for unmapped access.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). The polarity and synchronicity are fixed.
- Reset, and the next edge whenever rst=1: state=IDLE; cs=0, cs_we=0, region=0, busy=0, rdy=0, err=0, wait counter=0.
- rst has priority over every other input. Reset during ACCESS aborts the access: cs drops and no rdy/err is issued.
- States: IDLE, ACCESS, ERR.
- IDLE, en=0: stay in IDLE; all outputs except region are 0.
- IDLE, en=1, at edge T: capture region, we, and cnt = WAIT_CFG[4*region +: 4].
  - Mapped region: go to ACCESS; cs[region]=1, cs_we=we, busy=1 from T.
  - Unmapped region: go to ERR; cs stays 0, busy=1.
- ACCESS: cs is held for WAIT+1 cycles.
  - cnt != 0: decrement cnt and stay.
  - cnt == 0: rdy=1 in this cycle; at the next edge go to IDLE and clear cs, cs_we, busy.
  - Resulting latency: en sampled at edge T gives rdy high in cycle T+WAIT (relative to cs first high at T).
- ERR: lasts exactly one cycle with rdy=1, err=1, busy=1, cs=0; then IDLE.
- en, add and we are ignored while busy=1. Address changes mid-access do not affect cs or region.
- A request held high through rdy is accepted on the first IDLE edge. Minimum request-to-request spacing is WAIT+2 cycles.
- cs is always one-hot or zero. rdy and err are never high outside the final busy cycle.
- region holds its last captured value in IDLE.
- Wait nibble width is fixed at 4; the counter never wraps below 0.
- Compatibility: with SEL_W=3, region 7 (add[15:13]=3'b111) is the I/O region and regions 0-6 are memory.

Test Plan:
- Reset: assert rst for 2 cycles with en=1, add=16'hE000 -> cs=0, rdy=0, busy=0, err=0 throughout; after release, the first accepted request starts cleanly.
- Zero-wait memory read: en=1, add=16'h1234, we=0 for 1 cycle -> next cycle cs=8'h01, region=0, rdy=1, busy=1; following cycle cs=0, busy=0.
- I/O with 3 waits: en=1, add=16'hE010, we=1 -> cs=8'h80, cs_we=1 for 4 cycles; rdy high only in the 4th; en/add toggled during access have no effect.
- Unmapped: MAP_MASK=8'h81, en=1, add=16'h4000 -> one cycle later cs=0, rdy=1, err=1, busy=1; IDLE the cycle after.
- Back-to-back: en held high with add=16'h2000 then 16'hE000 -> second capture occurs the first IDLE edge after the first rdy; no overlap of cs bits.
- Reset mid-access: rst=1 in the 2nd cycle of the region-7 access -> cs=0, busy=0 next edge; no rdy pulse observed.
